// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch FSM state encoding and the PC width and defaults.
// No logic; imported by fetch_ctrl and pc_redirect_buf.
package fetch_pkg;

    localparam int              PC_W         = 32;
    localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned     PC_STEP_DEF  = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// Holds one redirect that arrived while instruction memory was not ready.
// Latency: captured value is visible on the cycle after capture.
// Backpressure: none; a new capture overwrites the held target, and capture wins over clear.
// Ports: clk/rst_n; capture + target_in load; clear drops valid; valid_out/target_out.
module pc_redirect_buf
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture,
    input  logic            clear,
    input  logic [PC_W-1:0] target_in,
    output logic            valid_out,
    output logic [PC_W-1:0] target_out
);

    logic            r_valid;
    logic [PC_W-1:0] r_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (capture) begin
            r_valid  <= 1'b1;
            r_target <= target_in;
        end else if (clear) begin
            r_valid  <= 1'b0;
        end
    end

    assign valid_out  = r_valid;
    assign target_out = r_target;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: sequences the PC, issues imem requests, handles redirects and misalignment.
// Latency: all PC/stall/flush outputs are combinational from state, pending and inputs.
// Backpressure: imem_ready=0 stalls the PC and holds imem_addr; redirects seen meanwhile are buffered.
// Ports: clk/rst_n; current_pc in, next_pc/pc_stall out to the PC register;
//        hazard_stall, redirect_valid/redirect_target in; imem_req/imem_addr/imem_ready;
//        if_id_flush/id_ex_flush out; misalign_err sticky until reset.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned     PC_STEP  = PC_STEP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] current_pc,
    input  logic            hazard_stall,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    output logic            pc_stall,
    output logic [PC_W-1:0] next_pc,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            misalign_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic            r_misalign_err;
    logic            w_set_err;
    logic            w_capture;
    logic            w_clear;
    logic            w_pend_vld;
    logic [PC_W-1:0] w_pend_tgt;
    logic            w_tgt_misaligned;

    assign w_tgt_misaligned = |redirect_target[1:0];
    assign imem_addr        = current_pc;
    assign misalign_err     = r_misalign_err;

    pc_redirect_buf u_redirect_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (w_capture),
        .clear      (w_clear),
        .target_in  (redirect_target),
        .valid_out  (w_pend_vld),
        .target_out (w_pend_tgt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_BOOT;
            r_misalign_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_err) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        pc_stall    = 1'b1;
        next_pc     = current_pc;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        w_capture   = 1'b0;
        w_clear     = 1'b0;
        w_set_err   = 1'b0;

        case (r_state)
            ST_BOOT: begin
                next_pc     = RESET_PC;
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH, ST_WAIT: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // A fresh redirect always squashes the younger instructions,
                    // even if it cannot be taken this cycle.
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (w_tgt_misaligned) begin
                        w_set_err   = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else if (imem_ready) begin
                        pc_stall    = 1'b0;
                        next_pc     = redirect_target;
                        w_clear     = 1'b1;
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end else if (!imem_ready) begin
                    w_state_nxt = ST_WAIT;
                end else if (w_pend_vld) begin
                    // Flush already happened when the redirect was captured.
                    pc_stall    = 1'b0;
                    next_pc     = w_pend_tgt;
                    w_clear     = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_FETCH;
                    if (!hazard_stall) begin
                        pc_stall = 1'b0;
                        next_pc  = current_pc + PC_W'(PC_STEP);
                    end
                end
            end

            default: begin
                // ST_HALT: everything idle until reset.
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an external PC register model.
// Latency: inputs applied 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: imem_ready driven directly by the stimulus.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] current_pc;
    logic        hazard_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        pc_stall;
    logic [31:0] next_pc;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        misalign_err;

    int n_checks;
    int n_pass;

    fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .current_pc      (current_pc),
        .hazard_stall    (hazard_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_ready      (imem_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .pc_stall        (pc_stall),
        .next_pc         (next_pc),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .misalign_err    (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The PC register the controller commands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            current_pc <= 32'h0000_0000;
        end else if (!pc_stall) begin
            current_pc <= next_pc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        hazard_stall    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ready      = 1'b1;

        // Reset state
        #2;
        chk("rst_req",   32'(imem_req),     32'd0);
        chk("rst_stall", 32'(pc_stall),     32'd1);
        chk("rst_npc",   next_pc,           32'h0);
        chk("rst_flush", 32'(if_id_flush | id_ex_flush), 32'd0);
        chk("rst_err",   32'(misalign_err), 32'd0);

        // Release reset: one BOOT cycle, then 0,4,8,12
        tick();
        rst_n = 1'b1;
        #1;
        chk("boot_req",   32'(imem_req), 32'd0);
        chk("boot_stall", 32'(pc_stall), 32'd1);
        tick();
        chk("seq_pc0",  current_pc,     32'h0);
        chk("seq_req",  32'(imem_req),  32'd1);
        chk("seq_npc0", next_pc,        32'h4);
        tick();
        chk("seq_pc1", current_pc, 32'h4);
        tick();
        chk("seq_pc2", current_pc, 32'h8);
        tick();
        chk("seq_pc3", current_pc, 32'hC);
        tick();
        chk("seq_pc4", current_pc, 32'h10);

        // imem not ready for 3 cycles at 0x10
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wait_addr",  imem_addr,      32'h10);
            chk("wait_stall", 32'(pc_stall),  32'd1);
            tick();
        end
        imem_ready = 1'b1;
        #1;
        chk("wait_pc",    current_pc,     32'h10);
        chk("wait_npc",   next_pc,        32'h14);
        chk("wait_go",    32'(pc_stall),  32'd0);
        tick();
        chk("wait_pc_after", current_pc, 32'h14);

        // Redirect beats hazard stall
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        hazard_stall    = 1'b1;
        #1;
        chk("rd_ifid",  32'(if_id_flush), 32'd1);
        chk("rd_idex",  32'(id_ex_flush), 32'd1);
        chk("rd_stall", 32'(pc_stall),    32'd0);
        chk("rd_npc",   next_pc,          32'h200);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("rd_pc",     current_pc,  32'h200);
        chk("hz_stall",  32'(pc_stall), 32'd1);
        chk("hz_flush",  32'(if_id_flush | id_ex_flush), 32'd0);
        tick();
        chk("hz_pc", current_pc, 32'h200);
        hazard_stall = 1'b0;

        // Two redirects while in WAIT; the newer one wins, no flush on release
        imem_ready = 1'b0;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        #1;
        chk("pend1_flush", 32'(if_id_flush), 32'd1);
        chk("pend1_stall", 32'(pc_stall),    32'd1);
        tick();
        redirect_target = 32'h100;
        #1;
        chk("pend2_flush", 32'(id_ex_flush), 32'd1);
        tick();
        redirect_valid = 1'b0;
        imem_ready     = 1'b1;
        #1;
        chk("pend_npc",   next_pc,          32'h100);
        chk("pend_stall", 32'(pc_stall),    32'd0);
        chk("pend_noflush", 32'(if_id_flush | id_ex_flush), 32'd0);
        tick();
        chk("pend_pc", current_pc, 32'h100);
        chk("pend_seq", next_pc,   32'h104);

        // PC wrap
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_pc",  current_pc, 32'hFFFF_FFFC);
        chk("wrap_npc", next_pc,    32'h0);
        tick();
        chk("wrap_pc0", current_pc, 32'h0);
        tick();
        chk("wrap_pc4", current_pc, 32'h4);

        // Misaligned redirect halts
        redirect_valid  = 1'b1;
        redirect_target = 32'h202;
        #1;
        chk("mis_flush", 32'(if_id_flush & id_ex_flush), 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("halt_err",   32'(misalign_err), 32'd1);
        chk("halt_req",   32'(imem_req),     32'd0);
        chk("halt_stall", 32'(pc_stall),     32'd1);
        chk("halt_flush", 32'(if_id_flush | id_ex_flush), 32'd0);
        tick();
        tick();
        chk("halt_err2", 32'(misalign_err), 32'd1);
        chk("halt_pc",   current_pc,        32'h4);
        rst_n = 1'b0;
        #1;
        chk("hrst_err",   32'(misalign_err), 32'd0);
        chk("hrst_stall", 32'(pc_stall),     32'd1);
        chk("hrst_req",   32'(imem_req),     32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("restart_pc",  current_pc, 32'h0);
        chk("restart_npc", next_pc,    32'h4);
        tick();

        // Reset during WAIT drops the pending redirect
        imem_ready      = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick();
        redirect_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("wrst_req", 32'(imem_req), 32'd0);
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        tick();
        chk("wrst_pc",  current_pc, 32'h0);
        chk("wrst_npc", next_pc,    32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
